// File: rtl/bitfusion_ctrl.sv
// bitfusion_ctrl: host-side sequencer for the bitfusion systolic array.
// Loads WBUF/IBUF from a word stream, issues skewed reads, drains, then streams column sums.
module bitfusion_ctrl #(
    parameter int ARRAY_SIZE = 4,
    parameter int DATA_W     = 32,
    parameter int BUF_DEPTH  = 8,
    parameter int DRAIN_LAT  = 4
) (
    input  logic                                               clk,
    input  logic                                               nRST,
    input  logic                                               start,
    input  logic                                               reuse_w,
    input  logic [DATA_W-1:0]                                  s_data,
    input  logic                                               s_valid,
    output logic                                               s_ready,
    output logic [DATA_W-1:0]                                  data_in,
    output logic [ARRAY_SIZE-1:0]                              IBUF_wr_en,
    output logic [ARRAY_SIZE*ARRAY_SIZE-1:0]                   WBUF_wr_en,
    output logic [ARRAY_SIZE-1:0]                              input_rd_en,
    output logic [ARRAY_SIZE*ARRAY_SIZE-1:0]                   weight_rd_en,
    output logic [ARRAY_SIZE-1:0]                              acc_clear,
    input  logic [ARRAY_SIZE*DATA_W-1:0]                       OBUF,
    output logic [DATA_W-1:0]                                  m_data,
    output logic [(ARRAY_SIZE > 1 ? $clog2(ARRAY_SIZE) : 1)-1:0] m_col,
    output logic                                               m_valid,
    input  logic                                               m_ready,
    output logic                                               busy,
    output logic                                               done
);

    localparam int NPE      = ARRAY_SIZE * ARRAY_SIZE;
    localparam int COMP_LEN = BUF_DEPTH + 2 * (ARRAY_SIZE - 1);
    localparam int COL_W    = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam int K_W      = $clog2(BUF_DEPTH + 1);
    localparam int PE_W     = $clog2(NPE + 1);
    localparam int CYC_MAX  = (COMP_LEN > DRAIN_LAT) ? COMP_LEN : DRAIN_LAT;
    localparam int CYC_W    = $clog2(CYC_MAX + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LOAD_I  = 3'd2,
        CLR     = 3'd3,
        COMPUTE = 3'd4,
        DRAIN   = 3'd5,
        OUTPUT  = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [PE_W-1:0]     pe_q, pe_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ARRAY_SIZE-1:0] ibuf_wr_q, ibuf_wr_d;
    logic [NPE-1:0]      wbuf_wr_q, wbuf_wr_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   cap_q [ARRAY_SIZE];
    logic [DATA_W-1:0]   cap_d [ARRAY_SIZE];

    logic load_active, accept;
    logic k_last, w_last, i_last, comp_last, drain_last, col_last;

    assign load_active = (state_q == LOAD_W) || (state_q == LOAD_I);
    assign accept      = s_valid && load_active;
    assign k_last      = (k_q == K_W'(BUF_DEPTH - 1));
    assign w_last      = (pe_q == PE_W'(NPE - 1));
    assign i_last      = (pe_q == PE_W'(ARRAY_SIZE - 1));
    assign comp_last   = (cyc_q == CYC_W'(COMP_LEN - 1));
    assign drain_last  = (cyc_q == CYC_W'(DRAIN_LAT - 1));
    assign col_last    = (col_q == COL_W'(ARRAY_SIZE - 1));

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = reuse_w ? LOAD_I : LOAD_W;
            LOAD_W:  if (accept && k_last && w_last) state_d = LOAD_I;
            LOAD_I:  if (accept && k_last && i_last) state_d = CLR;
            CLR:     state_d = COMPUTE;
            COMPUTE: if (comp_last) state_d = DRAIN;
            DRAIN:   if (drain_last) state_d = OUTPUT;
            OUTPUT:  if (m_ready && col_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Word/PE counters step per accepted word; pe clears when the load phase exits.
    always_comb begin
        k_d       = k_q;
        pe_d      = pe_q;
        cyc_d     = cyc_q;
        col_d     = col_q;
        data_d    = data_q;
        ibuf_wr_d = '0;
        wbuf_wr_d = '0;
        done_d    = 1'b0;
        cap_d     = cap_q;
        if (accept) begin
            data_d = s_data;
            if (state_q == LOAD_W) begin
                wbuf_wr_d = NPE'(1) << pe_q;
            end else begin
                ibuf_wr_d = ARRAY_SIZE'(1) << pe_q;
            end
            if (k_last) begin
                k_d  = '0;
                pe_d = ((state_q == LOAD_W) ? w_last : i_last) ? '0 : pe_q + 1'b1;
            end else begin
                k_d = k_q + 1'b1;
            end
        end
        if (state_q == COMPUTE) begin
            cyc_d = comp_last ? '0 : cyc_q + 1'b1;
        end
        if (state_q == DRAIN) begin
            cyc_d = drain_last ? '0 : cyc_q + 1'b1;
            if (drain_last) begin
                for (int c = 0; c < ARRAY_SIZE; c++) begin
                    cap_d[c] = OBUF[c*DATA_W +: DATA_W];
                end
            end
        end
        if (state_q == OUTPUT && m_ready) begin
            col_d  = col_last ? '0 : col_q + 1'b1;
            done_d = col_last;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            k_q       <= '0;
            pe_q      <= '0;
            cyc_q     <= '0;
            col_q     <= '0;
            data_q    <= '0;
            ibuf_wr_q <= '0;
            wbuf_wr_q <= '0;
            done_q    <= 1'b0;
            for (int c = 0; c < ARRAY_SIZE; c++) begin
                cap_q[c] <= '0;
            end
        end else begin
            k_q       <= k_d;
            pe_q      <= pe_d;
            cyc_q     <= cyc_d;
            col_q     <= col_d;
            data_q    <= data_d;
            ibuf_wr_q <= ibuf_wr_d;
            wbuf_wr_q <= wbuf_wr_d;
            done_q    <= done_d;
            cap_q     <= cap_d;
        end
    end

    // Read windows are offset by row (and column for weights) to match the array's forward skew.
    always_comb begin
        s_ready      = load_active;
        busy         = (state_q != IDLE);
        acc_clear    = (state_q == CLR) ? '1 : '0;
        m_valid      = (state_q == OUTPUT);
        m_data       = (state_q == OUTPUT) ? cap_q[col_q] : '0;
        input_rd_en  = '0;
        weight_rd_en = '0;
        if (state_q == COMPUTE) begin
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                input_rd_en[i] = (int'(cyc_q) >= i) && (int'(cyc_q) < i + BUF_DEPTH);
                for (int j = 0; j < ARRAY_SIZE; j++) begin
                    weight_rd_en[i*ARRAY_SIZE+j] =
                        (int'(cyc_q) >= i + j) && (int'(cyc_q) < i + j + BUF_DEPTH);
                end
            end
        end
    end

    assign data_in    = data_q;
    assign IBUF_wr_en = ibuf_wr_q;
    assign WBUF_wr_en = wbuf_wr_q;
    assign m_col      = col_q;
    assign done       = done_q;

endmodule

// File: tb/tb_bitfusion_ctrl.sv
// tb_bitfusion_ctrl: table of tile scenarios plus a reset-abort sequence, each cycle compared
// against a timeline model (words accepted -> CLR -> COMPUTE -> DRAIN -> OUTPUT).
module tb_bitfusion_ctrl;

    localparam int N      = 4;
    localparam int DW     = 32;
    localparam int K      = 8;
    localparam int DL     = 4;
    localparam int NPE    = N * N;
    localparam int T_LEN  = K + 2 * (N - 1);
    localparam int NVEC   = 6;

    logic              clk = 1'b0;
    logic              nRST;
    logic              start;
    logic              reuse_w;
    logic [DW-1:0]     s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     data_in;
    logic [N-1:0]      IBUF_wr_en;
    logic [NPE-1:0]    WBUF_wr_en;
    logic [N-1:0]      input_rd_en;
    logic [NPE-1:0]    weight_rd_en;
    logic [N-1:0]      acc_clear;
    logic [N*DW-1:0]   OBUF;
    logic [DW-1:0]     m_data;
    logic [1:0]        m_col;
    logic              m_valid;
    logic              m_ready;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    bitfusion_ctrl #(
        .ARRAY_SIZE (N),
        .DATA_W     (DW),
        .BUF_DEPTH  (K),
        .DRAIN_LAT  (DL)
    ) dut (
        .clk          (clk),
        .nRST         (nRST),
        .start        (start),
        .reuse_w      (reuse_w),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .data_in      (data_in),
        .IBUF_wr_en   (IBUF_wr_en),
        .WBUF_wr_en   (WBUF_wr_en),
        .input_rd_en  (input_rd_en),
        .weight_rd_en (weight_rd_en),
        .acc_clear    (acc_clear),
        .OBUF         (OBUF),
        .m_data       (m_data),
        .m_col        (m_col),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        bit            reuse;
        int            vmode;
        int            rmode;
        bit            poke;
        logic [N*DW-1:0] obuf;
        int            exp_wpulses;
        int            exp_ipulses;
        int            exp_clr;
        int            exp_w33;
        int            exp_done;
    } tile_vec_t;

    tile_vec_t vecs [NVEC];

    int n_checks = 0;
    int n_errors = 0;

    logic          e_s_ready;
    logic [DW-1:0] e_data_in;
    logic [N-1:0]  e_ibuf;
    logic [NPE-1:0] e_wbuf;
    logic [N-1:0]  e_in_rd;
    logic [NPE-1:0] e_w_rd;
    logic [N-1:0]  e_acc;
    logic          e_m_valid;
    logic [DW-1:0] e_m_data;
    logic [1:0]    e_m_col;
    logic          e_busy;
    logic          e_done;
    bit            chk_mdata_always;
    logic [DW-1:0] last_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic clear_exp(input logic busy_v);
        e_s_ready = 1'b0;
        e_data_in = last_data;
        e_ibuf    = '0;
        e_wbuf    = '0;
        e_in_rd   = '0;
        e_w_rd    = '0;
        e_acc     = '0;
        e_m_valid = 1'b0;
        e_m_data  = '0;
        e_m_col   = '0;
        e_busy    = busy_v;
        e_done    = 1'b0;
    endtask

    task automatic check_output();
        chk("s_ready", s_ready, e_s_ready);
        chk("data_in", data_in, e_data_in);
        chk("IBUF_wr_en", IBUF_wr_en, e_ibuf);
        chk("WBUF_wr_en", WBUF_wr_en, e_wbuf);
        chk("input_rd_en", input_rd_en, e_in_rd);
        chk("weight_rd_en", weight_rd_en, e_w_rd);
        chk("acc_clear", acc_clear, e_acc);
        chk("m_valid", m_valid, e_m_valid);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        if (e_m_valid || chk_mdata_always) begin
            chk("m_data", m_data, e_m_data);
            chk("m_col", m_col, e_m_col);
        end
    endtask

    function automatic logic [N*DW-1:0] rand_obuf();
        logic [N*DW-1:0] r;
        for (int c = 0; c < N; c++) r[c*DW +: DW] = $urandom;
        return r;
    endfunction

    function automatic tile_vec_t mk_vec(input bit reuse, input int vmode, input int rmode,
                                         input bit poke, input logic [N*DW-1:0] obuf);
        tile_vec_t v;
        v.reuse       = reuse;
        v.vmode       = vmode;
        v.rmode       = rmode;
        v.poke        = poke;
        v.obuf        = obuf;
        v.exp_wpulses = reuse ? 0 : NPE * K;
        v.exp_ipulses = N * K;
        v.exp_clr     = 1;
        v.exp_w33     = K;
        v.exp_done    = 1;
        return v;
    endfunction

    // Runs one tile described by vecs[idx], checking every cycle against the timeline model.
    task automatic apply_stimulus(input int idx);
        tile_vec_t v;
        int nw, ntot, sent, cyc, c, col, out_start, t;
        int wp, ip, clr_cnt, w33, done_cnt;
        bit pend, pend_w, finished, vld, rdy;
        int pend_idx;
        logic [N*DW-1:0] obuf_exp;
        v = vecs[idx];
        nw = v.reuse ? 0 : NPE * K;
        ntot = nw + N * K;
        sent = 0; cyc = 0; pend = 0; pend_w = 0; pend_idx = 0;
        wp = 0; ip = 0; clr_cnt = 0; w33 = 0; done_cnt = 0;
        obuf_exp = v.obuf;
        OBUF = v.obuf;
        chk_mdata_always = 0;

        clear_exp(1'b0);
        check_output();
        start = 1'b1; reuse_w = v.reuse; s_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;

        while (sent < ntot && cyc < 5000) begin
            clear_exp(1'b1);
            e_s_ready = 1'b1;
            if (pend) begin
                if (pend_w) e_wbuf = NPE'(1) << pend_idx;
                else        e_ibuf = N'(1) << pend_idx;
            end
            check_output();
            wp += $countones(WBUF_wr_en);
            ip += $countones(IBUF_wr_en);
            done_cnt += int'(done);
            case (v.vmode)
                0:       vld = 1'b1;
                1:       vld = (cyc % 2 == 0);
                default: vld = 1'($urandom_range(0, 1));
            endcase
            s_valid = vld;
            s_data  = $urandom;
            pend    = vld;
            if (vld) begin
                last_data = s_data;
                pend_w    = (sent < nw);
                pend_idx  = pend_w ? sent / K : (sent - nw) / K;
                sent++;
            end
            reuse_w = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            if (v.poke) start = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        chk("load_budget", sent, ntot);

        out_start = 2 + T_LEN + DL;
        col = 0; finished = 0; c = 1;
        while (!finished && c < out_start + 200) begin
            clear_exp(1'b1);
            if (pend) begin
                if (pend_w) e_wbuf = NPE'(1) << pend_idx;
                else        e_ibuf = N'(1) << pend_idx;
            end
            if (c == 1) begin
                e_acc = '1;
            end else if (c >= 2 && c < 2 + T_LEN) begin
                t = c - 2;
                for (int i = 0; i < N; i++) begin
                    e_in_rd[i] = (t >= i) && (t < i + K);
                    for (int j = 0; j < N; j++)
                        e_w_rd[i*N+j] = (t >= i + j) && (t < i + j + K);
                end
            end else if (c >= out_start) begin
                e_m_valid = 1'b1;
                e_m_col   = 2'(col);
                e_m_data  = obuf_exp[col*DW +: DW];
            end
            check_output();
            wp += $countones(WBUF_wr_en);
            ip += $countones(IBUF_wr_en);
            clr_cnt += int'(acc_clear != '0);
            w33 += int'(weight_rd_en[NPE-1]);
            done_cnt += int'(done);
            pend = 0;
            s_valid = 1'($urandom_range(0, 1));
            s_data  = $urandom;
            reuse_w = 1'($urandom_range(0, 1));
            if (v.poke) start = 1'($urandom_range(0, 1));
            if (c >= out_start) begin
                if (c == out_start) OBUF = rand_obuf();
                case (v.rmode)
                    0:       rdy = 1'b1;
                    1:       rdy = (c - out_start >= 3);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                m_ready = rdy;
                if (rdy) begin
                    col++;
                    if (col == N) finished = 1;
                end
            end else begin
                m_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            c++;
        end
        chk("output_budget", finished, 1);

        start = 1'b0; m_ready = 1'b0; s_valid = 1'b0;
        clear_exp(1'b0);
        e_done = 1'b1;
        check_output();
        done_cnt += int'(done);
        @(negedge clk);
        clear_exp(1'b0);
        check_output();
        done_cnt += int'(done);

        chk("wbuf_pulses", wp, v.exp_wpulses);
        chk("ibuf_pulses", ip, v.exp_ipulses);
        chk("clr_cycles", clr_cnt, v.exp_clr);
        chk("w33_rd_cycles", w33, v.exp_w33);
        chk("done_pulses", done_cnt, v.exp_done);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = mk_vec(1'b0, 0, 0, 1'b0, rand_obuf());
        vecs[1] = mk_vec(1'b0, 1, 0, 1'b0, rand_obuf());
        vecs[2] = mk_vec(1'b1, 0, 0, 1'b0, rand_obuf());
        vecs[3] = mk_vec(1'b1, 0, 1, 1'b0, {32'd40, 32'd30, 32'd20, 32'd10});
        vecs[4] = mk_vec(1'b0, 2, 2, 1'b1, rand_obuf());
        vecs[5] = mk_vec(1'b1, 2, 2, 1'b1, rand_obuf());

        nRST = 1'b0; start = 1'b0; reuse_w = 1'b0; s_data = '0; s_valid = 1'b0;
        m_ready = 1'b0; OBUF = '0; last_data = '0; chk_mdata_always = 1;
        repeat (2) @(negedge clk);
        clear_exp(1'b0);
        check_output();
        nRST = 1'b1;
        @(negedge clk);

        // Abort a weight load mid-stream with an asynchronous reset.
        start = 1'b1; reuse_w = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 50; n++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            @(negedge clk);
        end
        nRST = 1'b0;
        #1;
        last_data = '0;
        clear_exp(1'b0);
        check_output();
        start = 1'b1;
        @(negedge clk);
        check_output();
        start = 1'b0; s_valid = 1'b0;
        nRST = 1'b1;
        @(negedge clk);
        check_output();

        for (int i = 0; i < NVEC; i++) begin
            $display("[TB] tile scenario %0d", i);
            apply_stimulus(i);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
